buzzer_tone_gen: RTL

//  Parametrised key-controlled buzzer tone generator, successor of the fixed-tap buzzer block.

---
 rtl/buzz_pkg.sv | 18 +
 rtl/key_debounce.sv | 41 ++++
 rtl/buzzer_tone_gen.sv | 118 +++++++++++
 3 files changed

// File: rtl/buzz_pkg.sv
// Shared types and helpers for the key-controlled buzzer tone generator.
// No logic or latency of its own; nothing here applies backpressure.
// Defaults describe the two-key board build.
package buzz_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_NUM_KEYS = 2;
  localparam int MAX_CODE     = (1 << DEF_NUM_KEYS) - 1;

  function automatic logic [31:0] half_of(input int unsigned base, input int unsigned code);
    return 32'(base) << code;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus stable-run counter for one active-low key; pressed=1 when held.
// Latency: 2 sync cycles plus DEB_CYCLES stable cycles before the output follows the key.
// No backpressure; a bounce simply restarts the stable count.
module key_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pressed
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1, sync2;
  logic [CW-1:0] stable_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      stable_cnt <= '0;
      pressed    <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      // Count only while the synced key disagrees with the reported state.
      if (~sync2 != pressed) begin
        if (stable_cnt == CW'(DEB_CYCLES - 1)) begin
          pressed    <= ~sync2;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + 1'b1;
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/buzzer_tone_gen.sv
// Key-selected square-wave buzzer; half-period BASE_HALF<<code, duty via vol when BUZZ_VOLUME_EN.
// Latency: buzz rises the cycle after en is sampled high; tone changes land on half-period edges.
// No backpressure; en=0 stops the tone on the next cycle.
module buzzer_tone_gen
  import buzz_pkg::*;
#(
  parameter int NUM_KEYS   = $clog2(MAX_CODE + 1),
  parameter int BASE_HALF  = 2048,
  parameter int DIV_W      = 16,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key,
  input  logic                en,
`ifdef BUZZ_VOLUME_EN
  input  logic [2:0]          vol,
`endif
  output logic                buzz,
  output logic [NUM_KEYS-1:0] led,
  output logic [NUM_KEYS-1:0] tone_code,
  output logic                busy
);

  state_t              state, state_nxt;
  logic [DIV_W-1:0]    cnt, cnt_nxt;
  logic                phase, phase_nxt;
  logic [NUM_KEYS-1:0] code_nxt;
  logic [DIV_W-1:0]    half;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_deb
    key_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .key_n  (key[i]),
      .pressed(led[i])
    );
  end

  assign half = DIV_W'(half_of(BASE_HALF, 32'(tone_code)));

`ifdef BUZZ_VOLUME_EN
  logic [2:0]       vol_q, vol_nxt;
  logic [DIV_W+2:0] high_len;

  assign high_len = ((DIV_W + 3)'(half) * (DIV_W + 3)'(vol_q)) >> 3;
  assign buzz     = (state == RUN) && phase && ({3'b000, cnt} < high_len);
`else
  assign buzz = (state == RUN) && phase;
`endif

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      phase     <= 1'b0;
      tone_code <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      phase     <= phase_nxt;
      tone_code <= code_nxt;
    end
  end

`ifdef BUZZ_VOLUME_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vol_q <= '0;
    else        vol_q <= vol_nxt;
  end
`endif

  // Code (and volume) are only picked up at entry or at a half-period boundary.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    phase_nxt = phase;
    code_nxt  = tone_code;
`ifdef BUZZ_VOLUME_EN
    vol_nxt   = vol_q;
`endif
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          phase_nxt = 1'b1;
          code_nxt  = led;
`ifdef BUZZ_VOLUME_EN
          vol_nxt   = vol;
`endif
        end
      end
      RUN: begin
        if (!en) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          phase_nxt = 1'b0;
        end else if (cnt == half - 1'b1) begin
          cnt_nxt   = '0;
          phase_nxt = ~phase;
          code_nxt  = led;
`ifdef BUZZ_VOLUME_EN
          vol_nxt   = vol;
`endif
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
